integ_dump_ctrl: RTL and testbench

Integrate-and-dump sequencer that owns one signed accumulator and accumulates a programmable window of input samples. At the end of each window it dumps the result to a held output register and restarts from zero. It sits between a sample source, for example a mixer or decimator output, and a downstream consumer that uses a valid/ready handshake. It supports single-shot and continuous windows, abort, and optional saturation.

---
 rtl/integ_pkg.sv | 25 ++
 rtl/acc_core.sv | 53 +++++
 rtl/integ_dump_ctrl.sv | 136 +++++++++++++
 tb/tb_integ_dump_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integ_pkg.sv
// Shared types and helpers for the integrate-and-dump block:
// FSM state encoding, saturation limits and sign extension.
package integ_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Limits are returned as 64-bit signed values so callers compare at full width.
  function automatic logic [63:0] sat_max(input int aw);
    return (64'd1 << (aw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int aw);
    return ~sat_max(aw);
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    t = $signed(v << (64 - w));
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/acc_core.sv
// Signed accumulator with clear/enable; o_nxt/o_ovf show the value after adding i_din.
// Wraps or clamps on overflow depending on SAT; no handshake, the owner gates i_en.
module acc_core
  import integ_pkg::*;
#(
  parameter int   W   = 10,
  parameter int   AW  = 16,
  parameter logic SAT = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [W-1:0]  i_din,
  output logic [AW-1:0] o_nxt,
  output logic          o_ovf
);

  localparam logic [63:0]   MAX64 = sat_max(AW);
  localparam logic [63:0]   MIN64 = sat_min(AW);
  localparam logic [AW-1:0] MAXV  = MAX64[AW-1:0];
  localparam logic [AW-1:0] MINV  = MIN64[AW-1:0];

  logic [AW-1:0] r_acc;
  logic [63:0]   w_sum;
  logic          w_ovf;
  logic [AW-1:0] w_nxt;

  // The sum is formed at 64 bits so the range check is exact for any AW.
  assign w_sum = sext({{(64-AW){1'b0}}, r_acc}, AW) + sext({{(64-W){1'b0}}, i_din}, W);
  assign w_ovf = ($signed(w_sum) > $signed(MAX64)) || ($signed(w_sum) < $signed(MIN64));

  always_comb begin
    w_nxt = w_sum[AW-1:0];
    if (SAT && w_ovf) begin
      w_nxt = w_sum[63] ? MINV : MAXV;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_nxt;
    end
  end

  assign o_nxt = w_nxt;
  assign o_ovf = w_ovf;

endmodule

// File: rtl/integ_dump_ctrl.sv
// Integrate-and-dump sequencer: sums win_len samples, dout valid one cycle after the last one.
// dout is held until dout_rdy; a new dump over an unread one overwrites it and sets sticky drop.
module integ_dump_ctrl
  import integ_pkg::*;
#(
  parameter int   W   = 10,
  parameter int   AW  = 16,
  parameter int   CW  = 8,
  parameter logic SAT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 cont,
  input  logic                 abort,
  input  logic [CW-1:0]        win_len,
  input  logic                 din_vld,
  input  logic signed [W-1:0]  din,
  output logic signed [AW-1:0] dout,
  output logic                 dout_ovf,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic                 busy,
  output logic                 drop
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic          r_cont;
  logic          r_ovf;
  logic [AW-1:0] r_dout;
  logic          r_dout_ovf;
  logic          r_dout_vld;
  logic          r_drop;

  logic          w_start;
  logic          w_abort;
  logic          w_take;
  logic          w_last;
  logic          w_dump;
  logic          w_clr;
  logic [AW-1:0] w_nxt;
  logic          w_core_ovf;

  assign w_start = (r_state == ST_IDLE) && start && !abort;
  assign w_abort = (r_state == ST_ACC) && abort;
  assign w_take  = (r_state == ST_ACC) && din_vld && !abort;
  // A length of zero wraps len-1 to all ones, giving a 2^CW sample window.
  assign w_last  = (r_cnt == (r_len - CW'(1)));
  assign w_dump  = w_take && w_last;
  assign w_clr   = w_start || w_abort || w_dump;

  acc_core #(
    .W   (W),
    .AW  (AW),
    .SAT (SAT)
  ) u_acc (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (w_clr),
    .i_en  (w_take),
    .i_din (din),
    .o_nxt (w_nxt),
    .o_ovf (w_core_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_ACC;
      ST_ACC: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dump && !r_cont) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_cont  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_len  <= win_len;
        r_cont <= cont;
      end
      if (w_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_take) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_core_ovf) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout     <= '0;
      r_dout_ovf <= 1'b0;
      r_dout_vld <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (w_dump) begin
        r_dout     <= w_nxt;
        r_dout_ovf <= r_ovf || w_core_ovf;
        r_dout_vld <= 1'b1;
      end else if (r_dout_vld && dout_rdy) begin
        r_dout_vld <= 1'b0;
      end
      // Overwrite only counts as a drop when the consumer is not taking the old word.
      if (w_start) begin
        r_drop <= 1'b0;
      end else if (w_dump && r_dout_vld && !dout_rdy) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign dout     = r_dout;
  assign dout_ovf = r_dout_ovf;
  assign dout_vld = r_dout_vld;
  assign busy     = (r_state != ST_IDLE);
  assign drop     = r_drop;

endmodule

// File: tb/tb_integ_dump_ctrl.sv
// Bench for integ_dump_ctrl: directed scenarios plus randomized traffic against a window-sum model,
// run on an AW=16 wrap build and AW=10 wrap/saturate builds sharing the same inputs.
module tb_integ_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, start, cont, abort, din_vld, dout_rdy;
  logic [7:0]        win_len;
  logic signed [9:0] din;

  logic signed [15:0] dout_a;
  logic signed [9:0]  dout_b, dout_c;
  logic ovf_a, ovf_b, ovf_c, vld_a, vld_b, vld_c;
  logic busy_a, busy_b, busy_c, drop_a, drop_b, drop_c;

  int errors = 0;
  int checks = 0;

  integ_dump_ctrl #(.W(10), .AW(16), .CW(8), .SAT(1'b0)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .cont(cont), .abort(abort), .win_len(win_len),
    .din_vld(din_vld), .din(din), .dout(dout_a), .dout_ovf(ovf_a), .dout_vld(vld_a),
    .dout_rdy(dout_rdy), .busy(busy_a), .drop(drop_a));

  integ_dump_ctrl #(.W(10), .AW(10), .CW(8), .SAT(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .cont(cont), .abort(abort), .win_len(win_len),
    .din_vld(din_vld), .din(din), .dout(dout_b), .dout_ovf(ovf_b), .dout_vld(vld_b),
    .dout_rdy(dout_rdy), .busy(busy_b), .drop(drop_b));

  integ_dump_ctrl #(.W(10), .AW(10), .CW(8), .SAT(1'b1)) dut_c (
    .clk(clk), .rstn(rstn), .start(start), .cont(cont), .abort(abort), .win_len(win_len),
    .din_vld(din_vld), .din(din), .dout(dout_c), .dout_ovf(ovf_c), .dout_vld(vld_c),
    .dout_rdy(dout_rdy), .busy(busy_c), .drop(drop_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit c, input int len);
    start   = 1'b1;
    cont    = c;
    win_len = 8'(len);
    din_vld = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int x);
    din_vld = 1'b1;
    din     = 10'(x);
    step();
    din_vld = 1'b0;
  endtask

  // Adds one sample to a running window sum of width aw, wrapping or clamping on overflow.
  function automatic int acc_add(input int a, input int x, input int aw, input bit sat,
                                 inout bit ovf);
    int s, mx, mn;
    s  = a + x;
    mx = (1 << (aw - 1)) - 1;
    mn = -(1 << (aw - 1));
    if (s > mx || s < mn) begin
      ovf = 1'b1;
      if (sat) s = (s > mx) ? mx : mn;
      else     s = (s > mx) ? s - (1 << aw) : s + (1 << aw);
    end
    return s;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; win_len = 8'd0;
    din_vld = 1'b0; din = '0; dout_rdy = 1'b1;
    step(); step();
    checks++; if (dout_a !== 16'sd0) begin errors++; $display("FAIL reset_dout got=%0d exp=0", dout_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", vld_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (drop_a !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop_a); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    dout_rdy = 1'b1;
    do_start(1'b0, 4);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_start got=%b exp=1", busy_a); end
    send(1); send(2); send(3);
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL single_early_vld got=%b exp=0", vld_a); end
    send(4);
    checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL single_vld got=%b exp=1", vld_a); end
    checks++; if (dout_a !== 16'sd10) begin errors++; $display("FAIL single_dout got=%0d exp=10", dout_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b exp=0", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy_a); end
    step();
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL single_vld_clear got=%b exp=0", vld_a); end
  endtask

  task automatic test_cont();
    dout_rdy = 1'b1;
    do_start(1'b1, 3);
    for (int i = 1; i <= 9; i++) begin
      send(-5);
      if (i % 3 == 0) begin
        checks++; if (vld_a !== 1'b1 || dout_a !== -16'sd15) begin
          errors++; $display("FAIL cont_dump i=%0d got vld=%b dout=%0d exp vld=1 dout=-15", i, vld_a, dout_a);
        end
      end else begin
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL cont_gap i=%0d got vld=%b exp=0", i, vld_a); end
      end
    end
    checks++; if (drop_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL cont_state got drop=%b busy=%b exp drop=0 busy=1", drop_a, busy_a);
    end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL cont_abort_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_sat();
    dout_rdy = 1'b1;
    step();
    do_start(1'b0, 4);
    send(300); send(300); send(300); send(300);
    checks++; if (dout_a !== 16'sd1200 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL sat_wide got dout=%0d ovf=%b exp dout=1200 ovf=0", dout_a, ovf_a);
    end
    checks++; if (dout_b !== 10'sd176 || ovf_b !== 1'b1 || vld_b !== 1'b1) begin
      errors++; $display("FAIL sat_wrap got dout=%0d ovf=%b vld=%b exp dout=176 ovf=1 vld=1", dout_b, ovf_b, vld_b);
    end
    checks++; if (dout_c !== 10'sd511 || ovf_c !== 1'b1 || vld_c !== 1'b1) begin
      errors++; $display("FAIL sat_clamp got dout=%0d ovf=%b vld=%b exp dout=511 ovf=1 vld=1", dout_c, ovf_c, vld_c);
    end
    step();
  endtask

  task automatic test_drop();
    dout_rdy = 1'b0;
    do_start(1'b1, 2);
    send(1); send(2);
    checks++; if (vld_a !== 1'b1 || dout_a !== 16'sd3 || drop_a !== 1'b0) begin
      errors++; $display("FAIL drop_first got vld=%b dout=%0d drop=%b exp vld=1 dout=3 drop=0", vld_a, dout_a, drop_a);
    end
    send(3); send(4);
    checks++; if (dout_a !== 16'sd7 || drop_a !== 1'b1) begin
      errors++; $display("FAIL drop_overwrite got dout=%0d drop=%b exp dout=7 drop=1", dout_a, drop_a);
    end
    abort = 1'b1; dout_rdy = 1'b1;
    step();
    abort = 1'b0; dout_rdy = 1'b0;
    checks++; if (vld_a !== 1'b0 || drop_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL drop_sticky got vld=%b drop=%b busy=%b exp vld=0 drop=1 busy=0", vld_a, drop_a, busy_a);
    end
    step();
    checks++; if (drop_a !== 1'b1) begin errors++; $display("FAIL drop_hold got=%b exp=1", drop_a); end
    do_start(1'b0, 2);
    checks++; if (drop_a !== 1'b0) begin errors++; $display("FAIL drop_clear got=%b exp=0", drop_a); end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_abort();
    dout_rdy = 1'b1;
    do_start(1'b0, 8);
    for (int k = 0; k < 10; k++) begin
      din_vld = (k % 2 == 0);
      din     = 10'(k + 1);
      step();
      checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL abort_no_vld k=%0d got=%b exp=0", k, vld_a); end
    end
    abort = 1'b1; din_vld = 1'b1; din = 10'sd100;
    step();
    abort = 1'b0; din_vld = 1'b0;
    checks++; if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b vld=%b exp busy=0 vld=0", busy_a, vld_a);
    end
    do_start(1'b0, 2);
    send(7); send(7);
    checks++; if (vld_a !== 1'b1 || dout_a !== 16'sd14) begin
      errors++; $display("FAIL abort_restart got vld=%b dout=%0d exp vld=1 dout=14", vld_a, dout_a);
    end
  endtask

  task automatic test_reset_mid();
    dout_rdy = 1'b0;
    do_start(1'b1, 8);
    send(3); send(4); send(5);
    #2;
    rstn = 1'b0; start = 1'b1; abort = 1'b1; din_vld = 1'b1;
    #1;
    checks++; if (dout_a !== 16'sd0 || vld_a !== 1'b0 || ovf_a !== 1'b0 || drop_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got dout=%0d vld=%b ovf=%b drop=%b busy=%b exp all 0",
                         dout_a, vld_a, ovf_a, drop_a, busy_a);
    end
    step();
    rstn = 1'b1;
    step();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_start_ignored got busy=%b exp=0", busy_a); end
    start = 1'b0; abort = 1'b0; din_vld = 1'b0; dout_rdy = 1'b1;
    step();
    checks++; if (vld_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got vld=%b busy=%b exp 0 0", vld_a, busy_a);
    end
  endtask

  typedef struct packed {
    logic [2:0][31:0] v;
    logic [2:0]       o;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   macc[3];
    bit   movf[3];
    int   aws[3];
    bit   sats[3];
    int   gotv[3];
    bit   goto[3];
    bit   mbusy, mcont, pushed;
    int   mlen, mcnt, x;
    aws  = '{16, 10, 10};
    sats = '{1'b0, 1'b0, 1'b1};
    mbusy = 1'b0; mcont = 1'b0; mlen = 1; mcnt = 0;
    for (int i = 0; i < 3; i++) begin macc[i] = 0; movf[i] = 1'b0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 49) == 0);
      cont     = 1'($urandom_range(0, 1));
      win_len  = ($urandom_range(0, 40) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
      din_vld  = ($urandom_range(0, 3) != 0);
      din      = 10'($urandom_range(0, 1023));
      dout_rdy = 1'b1;
      x = int'(din);
      if (vld_a && dout_rdy) begin
        gotv[0] = int'(dout_a); gotv[1] = int'(dout_b); gotv[2] = int'(dout_c);
        goto[0] = ovf_a;        goto[1] = ovf_b;        goto[2] = ovf_c;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected cyc=%0d got dout=%0d exp no output", cyc, gotv[0]);
        end else begin
          e = q.pop_front();
          if (gotv[0] !== int'($signed(e.v[0])) || gotv[1] !== int'($signed(e.v[1])) ||
              gotv[2] !== int'($signed(e.v[2])) || goto[0] !== e.o[0] || goto[1] !== e.o[1] || goto[2] !== e.o[2]) begin
            errors++;
            $display("FAIL rand_dout cyc=%0d got %0d/%0d/%0d ovf %b%b%b exp %0d/%0d/%0d ovf %b%b%b", cyc,
                     gotv[0], gotv[1], gotv[2], goto[0], goto[1], goto[2],
                     int'($signed(e.v[0])), int'($signed(e.v[1])), int'($signed(e.v[2])), e.o[0], e.o[1], e.o[2]);
          end
        end
      end
      pushed = 1'b0;
      if (mbusy) begin
        if (abort) begin
          mbusy = 1'b0;
        end else if (din_vld) begin
          for (int i = 0; i < 3; i++) macc[i] = acc_add(macc[i], x, aws[i], sats[i], movf[i]);
          mcnt++;
          if (mcnt == mlen) begin
            for (int i = 0; i < 3; i++) begin
              e.v[i] = macc[i];
              e.o[i] = movf[i];
              macc[i] = 0;
              movf[i] = 1'b0;
            end
            q.push_back(e);
            pushed = 1'b1;
            mcnt = 0;
            if (!mcont) mbusy = 1'b0;
          end
        end
      end else if (start && !abort) begin
        mbusy = 1'b1;
        mcont = cont;
        mlen  = (win_len == 8'd0) ? 256 : int'(win_len);
        mcnt  = 0;
      end
      if (!mbusy || pushed || mcnt == 0) begin
        for (int i = 0; i < 3; i++) if (mcnt == 0) begin macc[i] = 0; movf[i] = 1'b0; end
      end
      step();
      checks++; if (busy_a !== mbusy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy_a, mbusy); end
      if (pushed) begin
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL rand_dump_vld cyc=%0d got=%b exp=1", cyc, vld_a); end
      end
    end
    start = 1'b0; abort = 1'b1; din_vld = 1'b0;
    if (vld_a) begin
      e = q.pop_front();
      checks++; if (int'(dout_a) !== int'($signed(e.v[0]))) begin
        errors++; $display("FAIL rand_tail got=%0d exp=%0d", dout_a, int'($signed(e.v[0])));
      end
    end
    step();
    abort = 1'b0;
    step();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_missing got=0 outputs exp=%0d more", q.size()); end
    checks++; if (drop_a !== 1'b0) begin errors++; $display("FAIL rand_drop got=%b exp=0", drop_a); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cont();
    test_sat();
    test_drop();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
